// File: rtl/rgb_fade_ctrl_if.sv
// Avalon-MM slave bus bundle for rgb_fade_ctrl.
//   address    : register select (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, driven combinationally by the slave
interface rgb_fade_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/rgb_fade_ctrl.sv
// RGB fade controller: an Avalon-MM slave that ramps a 24-bit RGB output one
// LSB per channel per step toward a software-written target, then raises an
// interrupt.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port : registered RGB output, R=[23:16] G=[15:8] B=[7:0]
//   irq      : interrupt, irq_pend & irq_en
// Register map: 0 CURRENT, 1 TARGET, 2 PERIOD, 3 CTRL {irq_en, irq_pend, busy}.
module rgb_fade_ctrl #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  rgb_fade_ctrl_if.slave bus,
  output logic [23:0]    out_port,
  output logic           irq
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t              state, state_next;
  logic [23:0]         target;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload;
  logic                irq_pend, irq_en;

  logic        wr, wr_cur, wr_tgt, wr_per, wr_ctrl;
  logic        tgt_hit, step_due, step_done;
  logic        busy, step_fire, done_set;
  logic [23:0] stepped;

  // Bus decode
  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_cur  = wr & (bus.address == 2'd0);
  assign wr_tgt  = wr & (bus.address == 2'd1);
  assign wr_per  = wr & (bus.address == 2'd2);
  assign wr_ctrl = wr & (bus.address == 2'd3);

  // A period of 0 behaves as 1 cycle per step
  assign reload = (period == '0) ? '0 : period - PERIOD_W'(1);

  // One-LSB move of each channel toward the target; never overshoots
  always_comb begin
    stepped = out_port;
    for (int unsigned i = 0; i < 3; i++) begin
      if (out_port[8*i +: 8] < target[8*i +: 8])
        stepped[8*i +: 8] = out_port[8*i +: 8] + 8'd1;
      else if (out_port[8*i +: 8] > target[8*i +: 8])
        stepped[8*i +: 8] = out_port[8*i +: 8] - 8'd1;
    end
  end

  assign tgt_hit   = (bus.writedata[23:0] == out_port);
  assign step_due  = (state == RAMP) && (cnt == '0);
  assign step_done = (stepped == target);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic; a CURRENT write overrides everything else
  always_comb begin
    state_next = state;
    if (wr_cur)
      state_next = IDLE;
    else if (wr_tgt)
      state_next = tgt_hit ? IDLE : RAMP;
    else if (step_due && step_done)
      state_next = IDLE;
  end

  // FSM outputs; a TARGET write in the step cycle retargets instead of stepping
  always_comb begin
    busy      = (state == RAMP);
    step_fire = step_due & ~wr_cur & ~wr_tgt;
    done_set  = (wr_tgt & tgt_hit) | (step_fire & step_done);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= '0;
      target   <= '0;
      period   <= '0;
      cnt      <= '0;
      irq_pend <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (wr_cur)
        out_port <= bus.writedata[23:0];
      else if (step_fire)
        out_port <= stepped;

      if (wr_tgt) target <= bus.writedata[23:0];
      if (wr_per) period <= bus.writedata[PERIOD_W-1:0];

      if (wr_tgt)
        cnt <= reload;
      else if (state == RAMP)
        cnt <= (cnt == '0) ? reload : cnt - PERIOD_W'(1);

      // Set beats a simultaneous write-1-to-clear
      if (done_set)
        irq_pend <= 1'b1;
      else if (wr_ctrl && bus.writedata[1])
        irq_pend <= 1'b0;

      if (wr_ctrl) irq_en <= bus.writedata[2];
    end
  end

  assign irq = irq_pend & irq_en;

  // Read mux, unused bits read as zero
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata = {8'd0, out_port};
      2'd1: bus.readdata = {8'd0, target};
      2'd2: bus.readdata = 32'(period);
      2'd3: bus.readdata = {29'd0, irq_en, irq_pend, busy};
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Directed self-checking bench for rgb_fade_ctrl.
module tb_rgb_fade_ctrl;

  logic        clk;
  logic        reset_n;
  logic [23:0] out_port;
  logic        irq;
  int          nvec;
  int          nerr;
  logic [31:0] rd;

  rgb_fade_ctrl_if bus ();

  rgb_fade_ctrl #(.PERIOD_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .out_port (out_port),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, ending 1 time unit after the last edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle write; returns 1 unit after the write edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset_n        = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // Mid-cycle asynchronous reset from a non-reset state
    bus_write(2'd0, 32'h00AA55AA);
    bus_write(2'd1, 32'h00AA55AA);   // target == current -> irq_pend
    bus_write(2'd3, 32'h4);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rst_out", {8'd0, out_port}, 32'h000000);
    bus_read(2'd3, rd);
    check("rst_ctrl", rd, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // PERIOD=4 ramp 0 -> 0x030201
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h0);
    bus_write(2'd3, 32'h4);
    bus_write(2'd1, 32'h00030201);
    cyc(3);
    check("p4_pre", {8'd0, out_port}, 32'h000000);
    cyc(1);
    check("p4_s1", {8'd0, out_port}, 32'h010101);
    bus_read(2'd3, rd);
    check("p4_busy", rd, 32'h5);
    cyc(4);
    check("p4_s2", {8'd0, out_port}, 32'h020201);
    cyc(4);
    check("p4_s3", {8'd0, out_port}, 32'h030201);
    bus_read(2'd3, rd);
    check("p4_done", rd, 32'h6);
    check("p4_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h2);
    check("p4_irqclr", {31'd0, irq}, 32'd0);
    bus_read(2'd3, rd);
    check("p4_ctrlclr", rd, 32'h0);

    // PERIOD=0: one step per cycle
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h00FF00FF);
    bus_write(2'd1, 32'h00FE01FD);
    cyc(1);
    check("p0_s1", {8'd0, out_port}, 32'hFE01FE);
    bus_read(2'd3, rd);
    check("p0_busy", rd, 32'h1);
    cyc(1);
    check("p0_s2", {8'd0, out_port}, 32'hFE01FD);
    bus_read(2'd3, rd);
    check("p0_done", rd, 32'h2);
    check("p0_irq_masked", {31'd0, irq}, 32'd0);
    bus_write(2'd3, 32'h2);

    // CURRENT write landing on the second step edge aborts the ramp
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'h00030201);
    cyc(4);
    check("ab_s1", {8'd0, out_port}, 32'h010101);
    cyc(2);
    bus_write(2'd0, 32'h00123456);
    check("ab_out", {8'd0, out_port}, 32'h123456);
    bus_read(2'd3, rd);
    check("ab_ctrl", rd, 32'h0);
    cyc(8);
    check("ab_hold", {8'd0, out_port}, 32'h123456);
    bus_read(2'd3, rd);
    check("ab_ctrl2", rd, 32'h0);

    // Retarget to current value mid-ramp
    bus_write(2'd0, 32'h0);
    bus_write(2'd3, 32'h4);
    bus_write(2'd1, 32'h00050505);
    cyc(4);
    check("rt_s1", {8'd0, out_port}, 32'h010101);
    bus_write(2'd1, 32'h00010101);
    bus_read(2'd3, rd);
    check("rt_ctrl", rd, 32'h6);
    check("rt_irq", {31'd0, irq}, 32'd1);
    cyc(8);
    check("rt_hold", {8'd0, out_port}, 32'h010101);
    bus_write(2'd3, 32'h6);
    bus_read(2'd3, rd);
    check("rt_w1c", rd, 32'h4);

    // W1C in the same cycle as completion: set wins
    bus_write(2'd1, 32'h00020202);
    cyc(2);
    bus_write(2'd3, 32'h6);
    check("sw_out", {8'd0, out_port}, 32'h020202);
    bus_read(2'd3, rd);
    check("sw_ctrl", rd, 32'h6);
    check("sw_irq", {31'd0, irq}, 32'd1);

    // Readback
    bus_write(2'd3, 32'h2);
    bus_write(2'd2, 32'h0000FFFF);
    bus_write(2'd1, 32'h00ABCDEF);
    bus_read(2'd2, rd);
    check("rb_period", rd, 32'h0000FFFF);
    bus_read(2'd1, rd);
    check("rb_target", rd, 32'h00ABCDEF);
    bus_read(2'd3, rd);
    check("rb_busy", rd & 32'h1, 32'h1);
    bus_read(2'd0, rd);
    check("rb_current", rd, 32'h00020202);
    bus_write(2'd0, 32'h0);
    bus_read(2'd3, rd);
    check("rb_idle", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
